// File: rtl/debounce_pkg.sv
// Default constants shared by the debouncer bank and its per-channel slice.
package debounce_pkg;
   localparam int DEF_NUM_CH        = 5;
   localparam int DEF_STABLE_CYCLES = 10000;
   localparam int DEF_REPEAT_DELAY  = 5000000;
   localparam int DEF_REPEAT_PERIOD = 1000000;
endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, symmetric stability filter, rise/fall strobes.
// Latency: pin step -> clean change in 2+STABLE_CYCLES cycles; no backpressure (free-running strobes).
// Auto-repeat strobe is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic noisy,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic repeat_p
);
   localparam int CW = $clog2(STABLE_CYCLES);

   if (STABLE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
      $error("debounce_channel: STABLE_CYCLES must be >= 2 and 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
   end

   logic          sync1;
   logic          sq;
   logic [CW-1:0] cnt;
   logic          flip;

   // The last disagreeing sample in a run of STABLE_CYCLES commits the new level.
   assign flip = (sq != clean) && (cnt == CW'(STABLE_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sq    <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= noisy ^ ACTIVE_LOW;
         sq    <= sync1;
         rise  <= flip & sq;
         fall  <= flip & ~sq;
         if (flip)
            clean <= sq;
         if (sq == clean || flip)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int HW = $clog2(REPEAT_DELAY + 1);

   logic [HW-1:0] hold;
   logic          hit;

   assign hit = (hold == HW'(REPEAT_DELAY - 1));

   // hold is 0 in the rise cycle; after a pulse it is reloaded so the next one lands REPEAT_PERIOD later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold     <= '0;
         repeat_p <= 1'b0;
      end else if (!clean || flip) begin
         hold     <= '0;
         repeat_p <= 1'b0;
      end else if (hit) begin
         hold     <= HW'(REPEAT_DELAY - REPEAT_PERIOD);
         repeat_p <= 1'b1;
      end else begin
         hold     <= hold + HW'(1);
         repeat_p <= 1'b0;
      end
   end
`else
   assign repeat_p = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N independent button debouncers; optional auto-repeat under DEBOUNCE_REPEAT_EN.
// Latency 2+STABLE_CYCLES cycles pin->clean; no backpressure, strobes are single-cycle.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int NUM_CH        = DEF_NUM_CH,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] noisy,
   output logic [NUM_CH-1:0] clean,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic [NUM_CH-1:0] repeat_p
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .noisy    (noisy[i]),
         .clean    (clean[i]),
         .rise     (rise[i]),
         .fall     (fall[i]),
         .repeat_p (repeat_p[i])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: per-cycle vector table plus a reset-mid-count sequence.
module tb_debounce_bank;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] noisy;
   logic [2:0] clean;
   logic [2:0] rise;
   logic [2:0] fall;
   logic [2:0] repeat_p;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] noisy;
      logic [2:0] clean;
      logic [2:0] rise;
      logic [2:0] fall;
      logic [2:0] rpt;
   } vec_t;

   vec_t tbl[$];

   debounce_bank #(
      .NUM_CH        (3),
      .STABLE_CYCLES (4),
      .ACTIVE_LOW    (1'b0),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .noisy    (noisy),
      .clean    (clean),
      .rise     (rise),
      .fall     (fall),
      .repeat_p (repeat_p)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] n, input logic [2:0] c, input logic [2:0] r,
                      input logic [2:0] f, input int reps);
      vec_t v;
      v.noisy = n;
      v.clean = c;
      v.rise  = r;
      v.fall  = f;
      v.rpt   = 3'b000;
      for (int k = 0; k < reps; k++)
         tbl.push_back(v);
   endtask

   initial begin
      // ch0 press at v2 -> rise at v7; ch1 glitches v8..v14; ch0 release at v20 -> fall at v25;
      // ch0+ch2 press at v28 -> rise at v33; release at v36 -> fall at v41.
      add(3'b000, 3'b000, 3'b000, 3'b000, 2);
      add(3'b001, 3'b000, 3'b000, 3'b000, 5);
      add(3'b001, 3'b001, 3'b001, 3'b000, 1);
      add(3'b011, 3'b001, 3'b000, 3'b000, 3);
      add(3'b001, 3'b001, 3'b000, 3'b000, 1);
      add(3'b011, 3'b001, 3'b000, 3'b000, 3);
      add(3'b001, 3'b001, 3'b000, 3'b000, 5);
      add(3'b000, 3'b001, 3'b000, 3'b000, 5);
      add(3'b000, 3'b000, 3'b000, 3'b001, 1);
      add(3'b000, 3'b000, 3'b000, 3'b000, 2);
      add(3'b101, 3'b000, 3'b000, 3'b000, 5);
      add(3'b101, 3'b101, 3'b101, 3'b000, 1);
      add(3'b101, 3'b101, 3'b000, 3'b000, 2);
      add(3'b000, 3'b101, 3'b000, 3'b000, 5);
      add(3'b000, 3'b000, 3'b000, 3'b101, 1);
      add(3'b000, 3'b000, 3'b000, 3'b000, 2);
`ifdef DEBOUNCE_REPEAT_EN
      // ch0 rises at v7 and stays clean through v24: pulses at +10, +13, +16.
      tbl[17].rpt = 3'b001;
      tbl[20].rpt = 3'b001;
      tbl[23].rpt = 3'b001;
`endif

      rst   = 1'b1;
      noisy = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      check("reset clean", clean, 3'b000);
      check("reset rise", rise, 3'b000);
      check("reset fall", fall, 3'b000);
      check("reset repeat", repeat_p, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         noisy = tbl[i].noisy;
         @(posedge clk);
         #1;
         check($sformatf("v%0d clean", i), clean, tbl[i].clean);
         check($sformatf("v%0d rise", i), rise, tbl[i].rise);
         check($sformatf("v%0d fall", i), fall, tbl[i].fall);
         check($sformatf("v%0d repeat", i), repeat_p, tbl[i].rpt);
      end

      // Reset in the middle of a count, with ch2 already clean-high.
      noisy = 3'b100;
      repeat (6) @(posedge clk);
      #1;
      check("pre-rst clean", clean, 3'b100);
      check("pre-rst rise", rise, 3'b100);
      noisy = 3'b101;
      repeat (4) @(posedge clk);
      #1;
      check("mid-count clean", clean, 3'b100);
      rst = 1'b1;
      #1;
      check("async rst clean", clean, 3'b000);
      check("async rst rise", rise, 3'b000);
      check("async rst fall", fall, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post-rst e%0d rise", k), rise, (k == 6) ? 3'b101 : 3'b000);
         check($sformatf("post-rst e%0d fall", k), fall, 3'b000);
         check($sformatf("post-rst e%0d clean", k), clean, (k >= 6) ? 3'b101 : 3'b000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
